// File: rtl/wb_resp_pkg.sv
// wb_resp_pkg: shared constants and source-code helpers for the
// Wishbone response collector (codes: 0 none, k+1 column k, DCOL+1 CSR).
package wb_resp_pkg;

  localparam int SRC_NONE = 0;

  function automatic int src_code(input int idx);
    return idx + 1;
  endfunction

  function automatic int csr_code(input int dcol);
    return dcol + 1;
  endfunction

endpackage

// File: rtl/wb_resp_collector_if.sv
// wb_resp_collector_if: slave responses in, collected master response out.
// slave = collector side, master = driver/observer side.
interface wb_resp_collector_if #(
  parameter int DCOL = 5,
  parameter int DW   = 8,
  parameter int CNTW = 8
);
  localparam int SW = $clog2(DCOL + 2);

  logic            wb_val_from_csr_i;
  logic            wb_ack_from_csr_i;
  logic [DW-1:0]   wb_dat_from_csr_i;
  logic [DCOL-1:0] wb_val_from_matrix_i;
  logic [DCOL-1:0] wb_ack_from_matrix_i;
  logic [DW-1:0]   wb_dat_from_matrix_i [DCOL-1:0];
  logic            wb_clr_i;
  logic            wb_ack_o;
  logic [DW-1:0]   wb_dat_from_o;
  logic [SW-1:0]   wb_src_o;
  logic            wb_err_o;
  logic [CNTW-1:0] wb_coll_cnt_o;

  modport slave (
    input  wb_val_from_csr_i,
    input  wb_ack_from_csr_i,
    input  wb_dat_from_csr_i,
    input  wb_val_from_matrix_i,
    input  wb_ack_from_matrix_i,
    input  wb_dat_from_matrix_i,
    input  wb_clr_i,
    output wb_ack_o,
    output wb_dat_from_o,
    output wb_src_o,
    output wb_err_o,
    output wb_coll_cnt_o
  );

  modport master (
    output wb_val_from_csr_i,
    output wb_ack_from_csr_i,
    output wb_dat_from_csr_i,
    output wb_val_from_matrix_i,
    output wb_ack_from_matrix_i,
    output wb_dat_from_matrix_i,
    output wb_clr_i,
    input  wb_ack_o,
    input  wb_dat_from_o,
    input  wb_src_o,
    input  wb_err_o,
    input  wb_coll_cnt_o
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: combinational round-robin pick of the first request
// at or after ptr (mod N); outputs one-hot gnt, its idx and any.
module wb_rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int PW = $clog2(N);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int o = 0; o < N; o++) begin
      k = (int'(ptr) + o) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_resp_collector.sv
// wb_resp_collector: per-source holding regs, CSR-priority / column RR
// arbitration, registered ack/dat/src, sticky overflow, collision count.
module wb_resp_collector
  import wb_resp_pkg::*;
#(
  parameter int DCOL = 5,
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  wb_resp_collector_if.slave bus
);
  localparam int SW = $clog2(DCOL + 2);
  localparam int PW = $clog2(DCOL);

  logic            csr_pres;
  logic [DCOL-1:0] col_pres;
  logic            csr_pend;
  logic [DW-1:0]   csr_hold;
  logic [DCOL-1:0] col_pend;
  logic [DW-1:0]   col_hold [DCOL];
  logic [PW-1:0]   rr;

  logic [DCOL-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic [DCOL-1:0] col_gnt;
  logic            col_any;

  logic            ovf;
  logic            coll;
  logic [DW-1:0]   nxt_dat;
  logic [SW-1:0]   nxt_src;

  logic            ack_q;
  logic [DW-1:0]   dat_q;
  logic [SW-1:0]   src_q;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;

  assign csr_pres = bus.wb_val_from_csr_i
                  & bus.wb_ack_from_csr_i;
  assign col_pres = bus.wb_val_from_matrix_i
                  & bus.wb_ack_from_matrix_i;

  wb_rr_arbiter #(.N(DCOL)) u_arb (
    .req (col_pend),
    .ptr (rr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // A pending CSR always wins, so it can never overflow itself.
  assign col_gnt = csr_pend ? '0 : arb_gnt;
  assign col_any = ~csr_pend & arb_any;

  assign ovf  = |(col_pres & col_pend & ~col_gnt);
  assign coll = $countones({col_pres, csr_pres}) >= 2;

  always_comb begin
    nxt_dat = '0;
    nxt_src = SW'(SRC_NONE);
    if (csr_pend) begin
      nxt_dat = csr_hold;
      nxt_src = SW'(csr_code(DCOL));
    end else if (arb_any) begin
      nxt_dat = col_hold[arb_idx];
      nxt_src = SW'(src_code(int'(arb_idx)));
    end
  end

  // A granted entry frees its slot this edge, so a same-cycle
  // presentation refills it instead of overflowing.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      csr_pend <= 1'b0;
      csr_hold <= '0;
      col_pend <= '0;
      for (int k = 0; k < DCOL; k++)
        col_hold[k] <= '0;
    end else begin
      if (csr_pres) begin
        csr_pend <= 1'b1;
        csr_hold <= bus.wb_dat_from_csr_i;
      end else if (csr_pend) begin
        csr_pend <= 1'b0;
      end
      for (int k = 0; k < DCOL; k++) begin
        if (col_pres[k] &&
            (!col_pend[k] || col_gnt[k])) begin
          col_pend[k] <= 1'b1;
          col_hold[k] <= bus.wb_dat_from_matrix_i[k];
        end else if (col_gnt[k]) begin
          col_pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rr <= '0;
    end else if (col_any) begin
      if (int'(arb_idx) == DCOL - 1)
        rr <= '0;
      else
        rr <= arb_idx + PW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      src_q <= '0;
    end else begin
      ack_q <= csr_pend | arb_any;
      dat_q <= nxt_dat;
      src_q <= nxt_src;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (bus.wb_clr_i) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (ovf)
        err_q <= 1'b1;
      if (coll && cnt_q != '1)
        cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.wb_ack_o      = ack_q;
  assign bus.wb_dat_from_o = dat_q;
  assign bus.wb_src_o      = src_q;
  assign bus.wb_err_o      = err_q;
  assign bus.wb_coll_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_resp_collector.sv
// tb_wb_resp_collector: table vectors, corner sequences and random
// traffic against a queue-free behavioural model (CNTW 8 and 2).
module tb_wb_resp_collector;

  localparam int DCOL = 5;
  localparam int DW   = 8;

  logic          clk;
  logic          rst;
  logic          csr_val, csr_ack;
  logic [7:0]    csr_dat;
  logic [4:0]    col_val, col_ack;
  logic [7:0]    col_dat [4:0];
  logic          clr;

  int checks = 0;
  int errors = 0;

  wb_resp_collector_if #(.DCOL(DCOL), .DW(DW), .CNTW(8)) b8 ();
  wb_resp_collector_if #(.DCOL(DCOL), .DW(DW), .CNTW(2)) b2 ();

  assign b8.wb_val_from_csr_i    = csr_val;
  assign b8.wb_ack_from_csr_i    = csr_ack;
  assign b8.wb_dat_from_csr_i    = csr_dat;
  assign b8.wb_val_from_matrix_i = col_val;
  assign b8.wb_ack_from_matrix_i = col_ack;
  assign b8.wb_dat_from_matrix_i = col_dat;
  assign b8.wb_clr_i             = clr;
  assign b2.wb_val_from_csr_i    = csr_val;
  assign b2.wb_ack_from_csr_i    = csr_ack;
  assign b2.wb_dat_from_csr_i    = csr_dat;
  assign b2.wb_val_from_matrix_i = col_val;
  assign b2.wb_ack_from_matrix_i = col_ack;
  assign b2.wb_dat_from_matrix_i = col_dat;
  assign b2.wb_clr_i             = clr;

  wb_resp_collector #(.DCOL(DCOL), .DW(DW), .CNTW(8)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (b8)
  );

  wb_resp_collector #(.DCOL(DCOL), .DW(DW), .CNTW(2)) u_sat (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference model: pending flags + held data per source,
  // collisions counted as an unbounded integer since last clear.
  bit       m_cp;
  int       m_cd;
  bit       m_p [DCOL];
  int       m_d [DCOL];
  int       m_rr;
  int       m_raw;
  int       e_ack, e_dat, e_src, e_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cp = 0; m_cd = 0; m_rr = 0; m_raw = 0;
    for (int k = 0; k < DCOL; k++) begin
      m_p[k] = 0; m_d[k] = 0;
    end
    e_ack = 0; e_dat = 0; e_src = 0; e_err = 0;
  endtask

  task automatic model_step();
    int  win;
    int  np;
    bit  ov;
    bit  cp;
    win = -1;
    ov  = 0;
    e_ack = 0; e_dat = 0; e_src = 0;
    if (m_cp) begin
      e_ack = 1; e_dat = m_cd; e_src = DCOL + 1;
      m_cp = 0;
    end else begin
      for (int o = 0; o < DCOL; o++)
        if (win < 0 && m_p[(m_rr + o) % DCOL])
          win = (m_rr + o) % DCOL;
      if (win >= 0) begin
        e_ack = 1; e_dat = m_d[win]; e_src = win + 1;
        m_p[win] = 0;
        m_rr = (win + 1) % DCOL;
      end
    end
    cp = csr_val && csr_ack;
    np = cp ? 1 : 0;
    if (cp) begin
      if (m_cp) ov = 1;
      else begin m_cp = 1; m_cd = csr_dat; end
    end
    for (int k = 0; k < DCOL; k++) begin
      if (col_val[k] && col_ack[k]) begin
        np++;
        if (m_p[k]) ov = 1;
        else begin m_p[k] = 1; m_d[k] = col_dat[k]; end
      end
    end
    if (clr) begin
      e_err = 0; m_raw = 0;
    end else begin
      if (ov) e_err = 1;
      if (np >= 2) m_raw++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("ack", int'(b8.wb_ack_o), e_ack);
    chk("dat", int'(b8.wb_dat_from_o), e_dat);
    chk("src", int'(b8.wb_src_o), e_src);
    chk("err", int'(b8.wb_err_o), e_err);
    chk("cnt8", int'(b8.wb_coll_cnt_o), (m_raw > 255) ? 255 : m_raw);
    chk("cnt2", int'(b2.wb_coll_cnt_o), (m_raw > 3) ? 3 : m_raw);
    chk("ack2", int'(b2.wb_ack_o), e_ack);
    chk("dat2", int'(b2.wb_dat_from_o), e_dat);
  endtask

  task automatic drive(input bit c, input int cd,
                       input logic [4:0] cols,
                       input logic [4:0] half,
                       input int d, input bit cl);
    csr_val = c; csr_ack = c; csr_dat = 8'(cd);
    col_val = cols | half; col_ack = cols;
    for (int k = 0; k < DCOL; k++) col_dat[k] = 8'(d);
    clr = cl;
  endtask

  task automatic idle();
    drive(0, 0, 5'b0, 5'b0, 0, 0);
  endtask

  typedef struct {
    bit         csr;
    int         cd;
    logic [4:0] cols;
    logic [4:0] half;
    int         d;
    bit         clr;
    int         eack;
    int         edat;
    int         esrc;
    int         eerr;
    int         ecnt;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(bit c, int cd, logic [4:0] cols,
                              logic [4:0] half, int d, bit cl,
                              int ea, int ed, int es, int ee, int ec);
    vec_t v;
    v.csr = c; v.cd = cd; v.cols = cols; v.half = half;
    v.d = d; v.clr = cl; v.eack = ea; v.edat = ed;
    v.esrc = es; v.eerr = ee; v.ecnt = ec;
    return v;
  endfunction

  initial begin
    tv.push_back(mk(0, 0,    5'b10011, 0, 8'h40, 0, 0, 0,     0, 0, 1));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h40, 1, 0, 1));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h40, 2, 0, 1));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h40, 5, 0, 1));
    tv.push_back(mk(0, 0,    5'b10001, 0, 8'h50, 0, 0, 0,     0, 0, 2));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h50, 1, 0, 2));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h50, 5, 0, 2));
    tv.push_back(mk(0, 0,    5'b00100, 0, 8'hA5, 0, 0, 0,     0, 0, 2));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'hA5, 3, 0, 2));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 0, 0,     0, 0, 2));
    tv.push_back(mk(1, 8'h11, 5'b00001, 0, 8'h22, 0, 0, 0,    0, 0, 3));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h11, 6, 0, 3));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h22, 1, 0, 3));
    tv.push_back(mk(0, 0,    0, 5'b01000, 8'h99, 0, 0, 0,     0, 0, 3));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 0, 0,     0, 0, 3));
    tv.push_back(mk(1, 8'h60, 5'b00010, 0, 8'h30, 0, 0, 0,    0, 0, 4));
    tv.push_back(mk(1, 8'h61, 5'b00010, 0, 8'h31, 0, 1, 8'h60, 6, 1, 5));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h61, 6, 1, 5));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 1, 8'h30, 2, 1, 5));
    tv.push_back(mk(0, 0,    0,        0, 0,     1, 0, 0,     0, 0, 0));
    tv.push_back(mk(0, 0,    0,        0, 0,     0, 0, 0,     0, 0, 0));

    rst = 1'b1;
    idle();
    model_reset();
    #2;
    chk("rst_ack", int'(b8.wb_ack_o), 0);
    chk("rst_dat", int'(b8.wb_dat_from_o), 0);
    chk("rst_src", int'(b8.wb_src_o), 0);
    chk("rst_err", int'(b8.wb_err_o), 0);
    chk("rst_cnt", int'(b8.wb_coll_cnt_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].csr, tv[i].cd, tv[i].cols, tv[i].half,
            tv[i].d, tv[i].clr);
      cycle();
      chk($sformatf("tv%0d_ack", i), int'(b8.wb_ack_o), tv[i].eack);
      chk($sformatf("tv%0d_dat", i), int'(b8.wb_dat_from_o), tv[i].edat);
      chk($sformatf("tv%0d_src", i), int'(b8.wb_src_o), tv[i].esrc);
      chk($sformatf("tv%0d_err", i), int'(b8.wb_err_o), tv[i].eerr);
      chk($sformatf("tv%0d_cnt", i), int'(b8.wb_coll_cnt_o), tv[i].ecnt);
    end

    // Counter saturation on the narrow instance, then clear vs collision.
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 5'b00011, 0, 8'h70 + n, 0);
      cycle();
    end
    chk("sat_cnt2", int'(b2.wb_coll_cnt_o), 3);
    chk("sat_cnt8", int'(b8.wb_coll_cnt_o), 4);
    drive(0, 0, 5'b00011, 0, 8'h7F, 1);
    cycle();
    chk("clr_cnt2", int'(b2.wb_coll_cnt_o), 0);
    chk("clr_cnt8", int'(b8.wb_coll_cnt_o), 0);
    chk("clr_err", int'(b8.wb_err_o), 0);
    idle();
    for (int n = 0; n < 10; n++) cycle();

    // Asynchronous reset while responses are in flight.
    drive(0, 0, 5'b01110, 0, 8'h77, 0);
    cycle();
    idle();
    cycle();
    chk("pre_rst_ack", int'(b8.wb_ack_o), 1);
    rst = 1'b1;
    drive(0, 0, 5'b00001, 0, 8'h55, 0);
    #1;
    chk("arst_ack", int'(b8.wb_ack_o), 0);
    chk("arst_dat", int'(b8.wb_dat_from_o), 0);
    chk("arst_src", int'(b8.wb_src_o), 0);
    cycle();
    rst = 1'b0;
    idle();
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("post_rst_ack", int'(b8.wb_ack_o), 0);
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      csr_val = ($urandom_range(0, 5) == 0);
      csr_ack = 1'(($urandom & 1) != 0);
      csr_dat = 8'($urandom);
      col_val = 5'($urandom);
      col_ack = 5'($urandom);
      for (int k = 0; k < DCOL; k++) col_dat[k] = 8'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle();
    for (int n = 0; n < 12; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
